// File: rtl/game_pkg.sv
// Shared definitions for the game sequencer and the score block.
//   - st command encodings (the score block compares against these)
//   - FSM state encoding
//   - st_of(): maps a state to the st command it drives
// Build option: GAME_PAUSE_EN adds the PAUSE state to the encoding.
package game_pkg;

    localparam logic [1:0] ST_HOLD = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_CLR  = 2'd2;

`ifdef GAME_PAUSE_EN
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        PAUSE = 3'd3,
        OVER  = 3'd4
    } game_state_e;
`else
    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        CLEAR = 3'd1,
        RUN   = 3'd2,
        OVER  = 3'd4
    } game_state_e;
`endif

    function automatic logic [1:0] st_of(input game_state_e s);
        logic [1:0] r;
        r = ST_HOLD;
        case (s)
            CLEAR:   r = ST_CLR;
            RUN:     r = ST_RUN;
            default: r = ST_HOLD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/key_debounce.sv
// Push-button debouncer for one active-low key.
// Ports:
//   clk    in  system clock
//   rst_n  in  asynchronous active-low reset
//   key_n  in  raw key, active-low, asynchronous to clk
//   level  out debounced key level (1 = released)
//   press  out one-cycle pulse on the debounced 1->0 transition
// The raw key is synchronised through two flops; a new level is accepted
// only after DEB_CYCLES consecutive samples disagree with the current level.
module key_debounce
    import game_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CW = (DEB_CYCLES > 1) ? $clog2(DEB_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX  = '1;

    logic [1:0]    sync_q;
    logic          sample;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          press_q, press_d;

    assign sample = sync_q[1];

    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        press_d = 1'b0;
        if (sample == level_q) begin
            cnt_d = '0;
        end else if (cnt_q >= CNT_LAST) begin
            level_d = sample;
            cnt_d   = '0;
            press_d = ~sample;
        end else if (cnt_q != CNT_MAX) begin
            // saturating guard: the counter must never wrap back to zero
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q  <= 2'b11;
            cnt_q   <= '0;
            level_q <= 1'b1;
            press_q <= 1'b0;
        end else begin
            sync_q  <= {sync_q[0], key_n};
            cnt_q   <= cnt_d;
            level_q <= level_d;
            press_q <= press_d;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/game_ctrl_fsm.sv
// Game sequencer: debounces the player keys, tracks the game lifecycle and
// drives the st command for the score/timer display block.
// Ports:
//   clk          in  system clock
//   rst_n        in  asynchronous active-low reset
//   key_start_n  in  raw start/restart key, active-low, async
//   key_pause_n  in  raw pause key, active-low, async (used only with GAME_PAUSE_EN)
//   hit          in  collision flag, synchronous, active-high
//   st           out score command: 0 hold, 1 run, 2 clear
//   game_over    out high while in OVER
//   led_run      out high while in RUN
// Build option: GAME_PAUSE_EN adds the pause debouncer and the PAUSE state.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | after reset, waiting for start; st=hold
// CLEAR | score block being cleared for CLR_CYCLES cycles; st=clear
// RUN   | game running; st=run, led_run=1
// PAUSE | game frozen by the pause key; st=hold (GAME_PAUSE_EN only)
// OVER  | collision seen; st=hold, game_over=1
module game_ctrl_fsm
    import game_pkg::*;
#(
    parameter int DEB_CYCLES = 1_000_000,
    parameter int CLR_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       key_start_n,
    input  logic       key_pause_n,
    input  logic       hit,
    output logic [1:0] st,
    output logic       game_over,
    output logic       led_run
);

    localparam logic [7:0] CLR_LOAD = 8'(CLR_CYCLES - 1);

    logic        start_press;
    logic        start_lvl_unused;
    logic        pause_press;

    game_state_e state_q, state_d;
    logic [7:0]  clr_cnt_q, clr_cnt_d;
    logic [1:0]  st_q;
    logic        over_q;
    logic        run_q;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_start (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_start_n),
        .level (start_lvl_unused),
        .press (start_press)
    );

`ifdef GAME_PAUSE_EN
    logic pause_lvl_unused;

    key_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_deb_pause (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (key_pause_n),
        .level (pause_lvl_unused),
        .press (pause_press)
    );
`else
    logic pause_key_unused;

    // pause key has no function in this build
    assign pause_key_unused = key_pause_n;
    assign pause_press      = 1'b0;
`endif

    // Priority inside each state: hit > start > pause.
    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        case (state_q)
            IDLE: begin
                if (start_press) state_d = CLEAR;
            end
            CLEAR: begin
                // start presses are deliberately ignored while clearing
                if (clr_cnt_q == 8'd0) state_d = RUN;
                else                   clr_cnt_d = clr_cnt_q - 8'd1;
            end
            RUN: begin
                if (hit)              state_d = OVER;
                else if (start_press) state_d = CLEAR;
`ifdef GAME_PAUSE_EN
                else if (pause_press) state_d = PAUSE;
`endif
            end
`ifdef GAME_PAUSE_EN
            PAUSE: begin
                if (start_press)      state_d = CLEAR;
                else if (pause_press) state_d = RUN;
            end
`endif
            OVER: begin
                if (start_press) state_d = CLEAR;
            end
            default: state_d = IDLE;
        endcase
        // load on every entry so st=clear lasts exactly CLR_CYCLES cycles
        if (state_d == CLEAR && state_q != CLEAR) clr_cnt_d = CLR_LOAD;
    end

    // Outputs are registered from the next state so they change on the
    // same edge as the state itself.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            clr_cnt_q <= 8'd0;
            st_q      <= ST_HOLD;
            over_q    <= 1'b0;
            run_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_cnt_q <= clr_cnt_d;
            st_q      <= st_of(state_d);
            over_q    <= (state_d == OVER);
            run_q     <= (state_d == RUN);
        end
    end

    assign st        = st_q;
    assign game_over = over_q;
    assign led_run   = run_q;

endmodule

// File: tb/tb_game_ctrl_fsm.sv
// Bench for game_ctrl_fsm with DEB_CYCLES=8, CLR_CYCLES=4. A reference model
// of the game rules is stepped on every clock edge and compared against the
// DUT outputs on every falling edge; directed scenarios are followed by a
// randomized key/hit phase.
module tb_game_ctrl_fsm;

    localparam int DEB = 8;
    localparam int CLR = 4;

    localparam int M_IDLE  = 0;
    localparam int M_CLEAR = 1;
    localparam int M_RUN   = 2;
    localparam int M_PAUSE = 3;
    localparam int M_OVER  = 4;

    logic       clk;
    logic       rst_n;
    logic       key_start_n;
    logic       key_pause_n;
    logic       hit;
    logic [1:0] st;
    logic       game_over;
    logic       led_run;

    int vectors;
    int miscompares;
    int n_clr;

    int m_mode;
    int m_left;
    bit m_s1[2];
    bit m_s2[2];
    bit m_lvl[2];
    bit m_press[2];
    bit m_hist[2][DEB];

    game_ctrl_fsm #(.DEB_CYCLES(DEB), .CLR_CYCLES(CLR)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .key_start_n (key_start_n),
        .key_pause_n (key_pause_n),
        .hit         (hit),
        .st          (st),
        .game_over   (game_over),
        .led_run     (led_run)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic void model_reset();
        m_mode = M_IDLE;
        m_left = 0;
        for (int k = 0; k < 2; k++) begin
            m_s1[k] = 1'b1;
            m_s2[k] = 1'b1;
            m_lvl[k] = 1'b1;
            m_press[k] = 1'b0;
            for (int i = 0; i < DEB; i++) m_hist[k][i] = 1'b1;
        end
    endfunction

    // A level is accepted once the last DEB synchronised samples all disagree with it.
    function automatic void deb_step(input int k, input bit raw);
        bit samp;
        bit all_diff;
        samp = m_s2[k];
        m_s2[k] = m_s1[k];
        m_s1[k] = raw;
        for (int i = DEB - 1; i > 0; i--) m_hist[k][i] = m_hist[k][i-1];
        m_hist[k][0] = samp;
        all_diff = 1'b1;
        for (int i = 0; i < DEB; i++) if (m_hist[k][i] == m_lvl[k]) all_diff = 1'b0;
        m_press[k] = 1'b0;
        if (all_diff) begin
            m_press[k] = m_lvl[k];
            m_lvl[k] = samp;
        end
    endfunction

    function automatic void model_step();
        bit sp;
        bit pp;
        sp = m_press[0];
`ifdef GAME_PAUSE_EN
        pp = m_press[1];
`else
        pp = 1'b0;
`endif
        case (m_mode)
            M_IDLE:  if (sp) begin m_mode = M_CLEAR; m_left = CLR; end
            M_CLEAR: if (m_left == 1) m_mode = M_RUN; else m_left--;
            M_RUN: begin
                if (hit) m_mode = M_OVER;
                else if (sp) begin m_mode = M_CLEAR; m_left = CLR; end
                else if (pp) m_mode = M_PAUSE;
            end
            M_PAUSE: begin
                if (sp) begin m_mode = M_CLEAR; m_left = CLR; end
                else if (pp) m_mode = M_RUN;
            end
            M_OVER:  if (sp) begin m_mode = M_CLEAR; m_left = CLR; end
            default: m_mode = M_IDLE;
        endcase
        deb_step(0, key_start_n);
        deb_step(1, key_pause_n);
    endfunction

    function automatic int exp_st();
        return (m_mode == M_CLEAR) ? 2 : (m_mode == M_RUN) ? 1 : 0;
    endfunction

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_step();
        else model_reset();
        @(negedge clk);
        chk("st", st, exp_st());
        chk("game_over", game_over, (m_mode == M_OVER) ? 1 : 0);
        chk("led_run", led_run, (m_mode == M_RUN) ? 1 : 0);
        if (st == 2'd2) n_clr++;
    endtask

    task automatic press_key(input int k, input int hold, input int after);
        if (k == 0) key_start_n = 1'b0; else key_pause_n = 1'b0;
        repeat (hold) cyc();
        if (k == 0) key_start_n = 1'b1; else key_pause_n = 1'b1;
        repeat (after) cyc();
    endtask

    initial begin
        bit aligned;
        bit found;
        int seg_s;
        int seg_p;

        vectors = 0;
        miscompares = 0;
        n_clr = 0;
        rst_n = 1'b0;
        key_start_n = 1'b1;
        key_pause_n = 1'b1;
        hit = 1'b0;
        model_reset();

        repeat (2) cyc();
        rst_n = 1'b1;
        chk("rst_st", st, 0);
        chk("rst_over", game_over, 0);
        chk("rst_led", led_run, 0);

        // key bouncing every 3 cycles never settles
        n_clr = 0;
        for (int i = 0; i < 30; i++) begin
            key_start_n = ((i / 3) % 2 == 0) ? 1'b0 : 1'b1;
            cyc();
            chk("bounce_st", st, 0);
        end
        key_start_n = 1'b1;
        repeat (12) cyc();
        chk("bounce_idle", st, 0);

        // clean start press: clear for CLR cycles, then run
        n_clr = 0;
        press_key(0, 12, 20);
        chk("start_clr_len", n_clr, CLR);
        chk("start_run_st", st, 1);
        chk("start_led", led_run, 1);

        // hit in run ends the game; start restarts it
        hit = 1'b1;
        cyc();
        hit = 1'b0;
        chk("hit_st", st, 0);
        chk("hit_over", game_over, 1);
        n_clr = 0;
        press_key(0, 12, 20);
        chk("restart_clr_len", n_clr, CLR);
        chk("restart_over", game_over, 0);
        chk("restart_st", st, 1);

        // hit coinciding with the start press: hit wins
        aligned = 1'b0;
        n_clr = 0;
        key_start_n = 1'b0;
        for (int i = 0; i < 16 && !aligned; i++) begin
            if (m_press[0]) begin
                hit = 1'b1;
                aligned = 1'b1;
            end
            cyc();
            hit = 1'b0;
        end
        key_start_n = 1'b1;
        repeat (20) cyc();
        chk("coincide_aligned", aligned, 1);
        chk("coincide_over", game_over, 1);
        chk("coincide_noclr", n_clr, 0);

        // back to run, then pause / resume
        press_key(0, 12, 20);
        n_clr = 0;
        press_key(1, 12, 20);
`ifdef GAME_PAUSE_EN
        chk("pause_st", st, 0);
`else
        chk("pause_st", st, 1);
`endif
        press_key(1, 12, 20);
        chk("resume_st", st, 1);
        chk("resume_noclr", n_clr, 0);

        // asynchronous reset in the middle of a clear
        found = 1'b0;
        key_start_n = 1'b0;
        for (int i = 0; i < 24 && !found; i++) begin
            cyc();
            if (m_mode == M_CLEAR) found = 1'b1;
        end
        key_start_n = 1'b1;
        chk("midclr_reached", found, 1);
        chk("midclr_st", st, 2);
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        chk("async_rst_st", st, 0);
        chk("async_rst_over", game_over, 0);
        chk("async_rst_led", led_run, 0);
        @(negedge clk);
        cyc();
        rst_n = 1'b1;
        n_clr = 0;
        repeat (20) cyc();
        chk("post_rst_st", st, 0);
        chk("post_rst_noclr", n_clr, 0);

        // randomized keys and hits
        seg_s = 0;
        seg_p = 0;
        for (int i = 0; i < 3000; i++) begin
            if (seg_s == 0) begin
                key_start_n = ($urandom_range(0, 2) != 0);
                seg_s = $urandom_range(1, 24);
            end
            if (seg_p == 0) begin
                key_pause_n = ($urandom_range(0, 2) != 0);
                seg_p = $urandom_range(1, 24);
            end
            seg_s--;
            seg_p--;
            hit = ($urandom_range(0, 19) == 0);
            rst_n = !(i >= 1500 && i < 1502);
            cyc();
        end
        rst_n = 1'b1;
        hit = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
